// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - control and serial pin bundle for spi_master
// master modport is the side that requests frames; slave modport is spi_master itself.
interface spi_master_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             spi_ck;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_nss;

  modport master (
    output start, tx_data, spi_miso,
    input  busy, done, rx_data, spi_ck, spi_mosi, spi_nss
  );

  modport slave (
    input  start, tx_data, spi_miso,
    output busy, done, rx_data, spi_ck, spi_mosi, spi_nss
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, one WIDTH-bit frame per accepted start
// Frame: SETUP, SHIFT (2*WIDTH SCK edges), HOLD, then GAP with nss high before IDLE.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 8
) (
  input  logic         clk,
  input  logic         nrst,
  spi_master_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int             EW        = $clog2(2 * WIDTH + 1);
  localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [EW-1:0]  EDGE_LAST = EW'(2 * WIDTH - 1);

  logic [2:0]       state_q,   state_d;
  logic [7:0]       div_q,     div_d;
  logic [EW-1:0]    edge_q,    edge_d;
  logic [WIDTH-1:0] tx_sr_q,   tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q,   rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             ck_q,      ck_d;
  logic             mosi_q,    mosi_d;
  logic             nss_q,     nss_d;

  logic div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ck_d      = ck_q;
    mosi_d    = mosi_q;
    nss_d     = nss_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETUP;
          tx_sr_d = bus.tx_data;
          mosi_d  = bus.tx_data[WIDTH-1];
          busy_d  = 1'b1;
          nss_d   = 1'b0;
          div_d   = 8'd0;
          edge_d  = '0;
        end
      end

      S_SETUP: begin
        if (div_wrap) begin
          div_d   = 8'd0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // SCK toggles at the end of every CLK_DIV-cycle half period.
      S_SHIFT: begin
        if (div_wrap) begin
          div_d  = 8'd0;
          ck_d   = ~ck_q;
          edge_d = edge_q + 1'b1;
          if (!ck_q) begin
            rx_sr_d = {rx_sr_q[WIDTH-2:0], bus.spi_miso};
          end else if (edge_q == EDGE_LAST) begin
            state_d = S_HOLD;
          end else begin
            // Rotation keeps every register bit live; only bit WIDTH-2 is presented next.
            tx_sr_d = {tx_sr_q[WIDTH-2:0], tx_sr_q[WIDTH-1]};
            mosi_d  = tx_sr_q[WIDTH-2];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (div_wrap) begin
          div_d     = 8'd0;
          state_d   = S_GAP;
          nss_d     = 1'b1;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_GAP: begin
        if (div_wrap) begin
          div_d   = 8'd0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        nss_d   = 1'b1;
        ck_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ck_q      <= 1'b0;
      mosi_q    <= 1'b0;
      nss_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ck_q      <= ck_d;
      mosi_q    <= mosi_d;
      nss_q     <= nss_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.spi_ck   = ck_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_nss  = nss_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master (CLK_DIV=4 and CLK_DIV=2 instances)
// Outputs are sampled on the falling clk edge; "cycle k" is the period after the k-th edge past accept.
module tb_spi_master;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic loop0 = 1'b1;
  logic miso0 = 1'b0;
  int   total = 0;
  int   bad = 0;

  spi_master_if #(.WIDTH(8)) bus0 ();
  spi_master_if #(.WIDTH(8)) bus2 ();

  spi_master #(.CLK_DIV(4), .WIDTH(8)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus0)
  );

  spi_master #(.CLK_DIV(2), .WIDTH(8)) u_dut2 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus2)
  );

  always #5 clk = ~clk;

  always_comb bus0.spi_miso = loop0 ? bus0.spi_mosi : miso0;
  always_comb bus2.spi_miso = bus2.spi_mosi;

  task automatic run0(input logic [7:0] tx, input int gk, input logic [7:0] gtx,
                      output int lat, output int busy_n, output int rises, output int dones,
                      output int rx_glitch, output logic [7:0] bits, output logic any_hi);
    int k;
    logic prev_ck;
    logic [7:0] prev_rx;
    lat = -1; busy_n = 0; rises = 0; dones = 0; rx_glitch = 0; bits = 8'h00; any_hi = 1'b0;
    @(posedge clk); #1;
    bus0.start = 1'b1; bus0.tx_data = tx;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    prev_ck = 1'b0;
    prev_rx = bus0.rx_data;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == gk) begin bus0.start = 1'b1; bus0.tx_data = gtx; end
      if (k == gk + 1) bus0.start = 1'b0;
      if (!bus0.busy) break;
      busy_n++;
      if (bus0.done) begin dones++; if (lat < 0) lat = k + 1; end
      if (bus0.spi_ck && !prev_ck) begin rises++; bits = {bits[6:0], bus0.spi_mosi}; end
      prev_ck = bus0.spi_ck;
      if (bus0.spi_mosi) any_hi = 1'b1;
      if (bus0.rx_data !== prev_rx && !bus0.done) rx_glitch++;
      prev_rx = bus0.rx_data;
    end
    total++;
    if (k >= 300) begin bad++; $display("FAIL run0_timeout cycles=%0d limit=300", k); end
  endtask

  task automatic test_reset;
    bus0.start = 1'b0; bus0.tx_data = 8'h00;
    bus2.start = 1'b0; bus2.tx_data = 8'h00;
    #1 nrst = 1'b0;
    #1;
    total++; if (bus0.spi_nss !== 1'b1) begin bad++; $display("FAIL reset_nss got=%b exp=1", bus0.spi_nss); end
    total++; if (bus0.spi_ck !== 1'b0) begin bad++; $display("FAIL reset_ck got=%b exp=0", bus0.spi_ck); end
    total++; if (bus0.spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus0.spi_mosi); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
    total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
    total++; if (bus0.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h exp=00", bus0.rx_data); end
    repeat (3) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_loopback;
    int lat, busy_n, rises, dones, rxg;
    logic [7:0] bits;
    logic hi;
    loop0 = 1'b1;
    run0(8'hA5, -5, 8'h00, lat, busy_n, rises, dones, rxg, bits, hi);
    total++; if (lat != 73) begin bad++; $display("FAIL lb_done_latency got=%0d exp=73", lat); end
    total++; if (busy_n != 76) begin bad++; $display("FAIL lb_busy_cycles got=%0d exp=76", busy_n); end
    total++; if (rises != 8) begin bad++; $display("FAIL lb_ck_rises got=%0d exp=8", rises); end
    total++; if (dones != 1) begin bad++; $display("FAIL lb_done_count got=%0d exp=1", dones); end
    total++; if (bus0.rx_data !== 8'hA5) begin bad++; $display("FAIL lb_rx got=%h exp=a5", bus0.rx_data); end
    total++; if (bits !== 8'hA5) begin bad++; $display("FAIL lb_mosi_bits got=%h exp=a5", bits); end
    total++; if (rxg != 0) begin bad++; $display("FAIL lb_rx_stable got=%0d exp=0", rxg); end
    total++; if (bus0.spi_nss !== 1'b1) begin bad++; $display("FAIL lb_idle_nss got=%b exp=1", bus0.spi_nss); end
  endtask

  task automatic test_miso_high;
    int lat, busy_n, rises, dones, rxg;
    logic [7:0] bits;
    logic hi;
    loop0 = 1'b0; miso0 = 1'b1;
    run0(8'h00, -5, 8'h00, lat, busy_n, rises, dones, rxg, bits, hi);
    total++; if (hi !== 1'b0) begin bad++; $display("FAIL mh_mosi_low got=%b exp=0", hi); end
    total++; if (bus0.rx_data !== 8'hFF) begin bad++; $display("FAIL mh_rx got=%h exp=ff", bus0.rx_data); end
    total++; if (dones != 1) begin bad++; $display("FAIL mh_done_count got=%0d exp=1", dones); end
    loop0 = 1'b1; miso0 = 1'b0;
  endtask

  task automatic test_ignored_start;
    int lat, busy_n, rises, dones, rxg, late_busy;
    logic [7:0] bits;
    logic hi;
    loop0 = 1'b1;
    run0(8'hA5, 10, 8'h3C, lat, busy_n, rises, dones, rxg, bits, hi);
    late_busy = 0;
    repeat (40) begin @(negedge clk); if (bus0.busy) late_busy++; end
    total++; if (dones != 1) begin bad++; $display("FAIL ig_done_count got=%0d exp=1", dones); end
    total++; if (bits !== 8'hA5) begin bad++; $display("FAIL ig_mosi_bits got=%h exp=a5", bits); end
    total++; if (bus0.rx_data !== 8'hA5) begin bad++; $display("FAIL ig_rx got=%h exp=a5", bus0.rx_data); end
    total++; if (busy_n != 76) begin bad++; $display("FAIL ig_busy_cycles got=%0d exp=76", busy_n); end
    total++; if (late_busy != 0) begin bad++; $display("FAIL ig_extra_frame got=%0d exp=0", late_busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] txv [0:2];
    logic [7:0] sent [0:2];
    logic [7:0] rxs [0:2];
    int gaps [0:1];
    int k, fi, dones, ngap, run;
    logic [7:0] bits;
    logic prev_ck;
    txv[0] = 8'h01; txv[1] = 8'h80; txv[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin sent[i] = 8'h00; rxs[i] = 8'h00; end
    gaps[0] = 0; gaps[1] = 0;
    fi = 0; dones = 0; ngap = 0; run = 0; bits = 8'h00; prev_ck = 1'b0;
    loop0 = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b1; bus0.tx_data = txv[0];
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus0.spi_nss) run++;
      else begin
        if (run > 0 && fi > 0 && ngap < 2) begin gaps[ngap] = run; ngap++; end
        run = 0;
      end
      if (bus0.spi_ck && !prev_ck) bits = {bits[6:0], bus0.spi_mosi};
      prev_ck = bus0.spi_ck;
      if (bus0.done) begin
        dones++;
        if (fi < 3) begin sent[fi] = bits; rxs[fi] = bus0.rx_data; end
        bits = 8'h00;
        fi++;
        if (fi < 3) bus0.tx_data = txv[fi];
        else bus0.start = 1'b0;
      end
      if (fi >= 3 && !bus0.busy) break;
    end
    bus0.start = 1'b0;
    total++; if (k >= 400) begin bad++; $display("FAIL b2b_timeout cycles=%0d limit=400", k); end
    total++; if (dones != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
    total++; if (gaps[0] != 5) begin bad++; $display("FAIL b2b_gap0 got=%0d exp=5", gaps[0]); end
    total++; if (gaps[1] != 5) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=5", gaps[1]); end
    for (int i = 0; i < 3; i++) begin
      total++; if (sent[i] !== txv[i]) begin bad++; $display("FAIL b2b_mosi%0d got=%h exp=%h", i, sent[i], txv[i]); end
      total++; if (rxs[i] !== txv[i]) begin bad++; $display("FAIL b2b_rx%0d got=%h exp=%h", i, rxs[i], txv[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int lat, busy_n, rises, dones, rxg, stray;
    logic [7:0] bits;
    logic hi;
    loop0 = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b1; bus0.tx_data = 8'h66;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (31) @(negedge clk);
    total++; if (bus0.spi_nss !== 1'b0) begin bad++; $display("FAIL rm_nss_before got=%b exp=0", bus0.spi_nss); end
    nrst = 1'b0;
    #1;
    total++; if (bus0.spi_nss !== 1'b1) begin bad++; $display("FAIL rm_nss got=%b exp=1", bus0.spi_nss); end
    total++; if (bus0.spi_ck !== 1'b0) begin bad++; $display("FAIL rm_ck got=%b exp=0", bus0.spi_ck); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", bus0.busy); end
    total++; if (bus0.rx_data !== 8'h00) begin bad++; $display("FAIL rm_rx got=%h exp=00", bus0.rx_data); end
    stray = 0;
    repeat (3) begin @(negedge clk); if (bus0.done) stray++; end
    nrst = 1'b1;
    repeat (100) begin @(negedge clk); if (bus0.done || bus0.busy) stray++; end
    total++; if (stray != 0) begin bad++; $display("FAIL rm_no_done got=%0d exp=0", stray); end
    total++; if (bus0.rx_data !== 8'h00) begin bad++; $display("FAIL rm_rx_after got=%h exp=00", bus0.rx_data); end
    run0(8'h3C, -5, 8'h00, lat, busy_n, rises, dones, rxg, bits, hi);
    total++; if (lat != 73) begin bad++; $display("FAIL rm_next_latency got=%0d exp=73", lat); end
    total++; if (bus0.rx_data !== 8'h3C) begin bad++; $display("FAIL rm_next_rx got=%h exp=3c", bus0.rx_data); end
  endtask

  task automatic test_clk_div2;
    int k, lat, rises, hi_run, hi_min, hi_max;
    logic prev_ck;
    lat = -1; rises = 0; hi_run = 0; hi_min = 999; hi_max = 0; prev_ck = 1'b0;
    @(posedge clk); #1;
    bus2.start = 1'b1; bus2.tx_data = 8'h5A;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus2.busy) break;
      if (bus2.done && lat < 0) lat = k + 1;
      if (bus2.spi_ck) begin
        if (!prev_ck) rises++;
        hi_run++;
      end else if (prev_ck) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      prev_ck = bus2.spi_ck;
    end
    total++; if (k >= 200) begin bad++; $display("FAIL d2_timeout cycles=%0d limit=200", k); end
    total++; if (lat != 37) begin bad++; $display("FAIL d2_done_latency got=%0d exp=37", lat); end
    total++; if (rises != 8) begin bad++; $display("FAIL d2_ck_rises got=%0d exp=8", rises); end
    total++; if (hi_min != 2 || hi_max != 2) begin bad++; $display("FAIL d2_half_period got=%0d..%0d exp=2", hi_min, hi_max); end
    total++; if (bus2.rx_data !== 8'h5A) begin bad++; $display("FAIL d2_rx got=%h exp=5a", bus2.rx_data); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_high();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_clk_div2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
